// File: rtl/uart_rx_engine.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_engine
//  Purpose  : Receive half of the UART. Synchronises the serial line,
//             oversamples it against a programmable bit time and deserialises
//             one frame: start bit, 7 or 8 data bits LSB first, optional
//             parity and one stop bit. Maintains RXRDY and the parity,
//             framing and overrun status flags read by the host interface.
//  Ports    :
//    clk        in   1      system clock
//    rst        in   1      asynchronous, active-high reset
//    rx         in   1      serial input, idle high
//    baud_k     in   DIV_W  clocks per bit (>= 4), stable while receiving
//    eight      in   1      1 = 8 data bits, 0 = 7 data bits
//    pen        in   1      1 = parity bit present
//    ohel       in   1      parity sense, 1 = odd, 0 = even
//    rd_strobe  in   1      host read of rx_data (one-clock pulse)
//    rx_data    out  8      last received byte (bit 7 is 0 in 7-bit mode)
//    rxrdy      out  1      byte available
//    perr       out  1      parity error on last frame
//    ferr       out  1      framing error on last frame
//    ovf        out  1      frame completed while rxrdy was still set
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_engine #(
   parameter int DIV_W  = 19,
   parameter int SYNC_N = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   input  logic [DIV_W-1:0] baud_k,
   input  logic             eight,
   input  logic             pen,
   input  logic             ohel,
   input  logic             rd_strobe,
   output logic [7:0]       rx_data,
   output logic             rxrdy,
   output logic             perr,
   output logic             ferr,
   output logic             ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

   state_t           state;
   state_t           state_nxt;

   logic [SYNC_N-1:0] sync_q;
   logic             rx_s;
   logic [DIV_W-1:0] bit_cnt;
   logic [3:0]       bit_idx;
   logic [9:0]       shreg;
   logic             wait_high;

   logic [3:0]       nbits;
   logic [DIV_W-1:0] half_m1;
   logic [DIV_W-1:0] full_m1;
   logic             mid_hit;
   logic             bit_hit;
   logic             last_bit;
   logic [8:0]       frame;
   logic [7:0]       data_new;
   logic             par_bit;
   logic             stop_bit;
   logic             perr_new;

   // ------------------------------------------------------------------
   // Input synchroniser; resets to the idle (high) line level
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_N-2:0], rx};
      end
   end

   assign rx_s = sync_q[SYNC_N-1];

   // ------------------------------------------------------------------
   // Frame geometry and sample-point detection
   // ------------------------------------------------------------------
   // Samples per frame after the start bit: data bits, parity, stop.
   assign nbits    = 4'd8 + {3'b000, eight} + {3'b000, pen};
   assign half_m1  = (baud_k >> 1) - CNT_ONE;
   assign full_m1  = baud_k - CNT_ONE;
   assign mid_hit  = (bit_cnt == half_m1);
   assign bit_hit  = (bit_cnt == full_m1);
   assign last_bit = (bit_idx == (nbits - 4'd1));

   // Samples enter at bit 9 and shift right, so a short frame sits in the
   // top nbits positions; shift it down so the first data bit lands at 0.
   // The stop bit is always the most recent sample, i.e. shreg[9].
   assign frame    = 9'(shreg >> (4'd10 - nbits));
   assign data_new = eight ? frame[7:0] : {1'b0, frame[6:0]};
   assign par_bit  = eight ? frame[8] : frame[7];
   assign stop_bit = shreg[9];
   assign perr_new = pen & ((^data_new ^ par_bit) != ohel);

   // ------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            // After a break the line must return high before re-arming.
            if (!rx_s && !wait_high) begin
               state_nxt = START;
            end
         end
         START: begin
            if (mid_hit) begin
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_hit && last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Bit timing, shift register and received byte
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         wait_high <= 1'b0;
         rx_data   <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               if (rx_s) begin
                  wait_high <= 1'b0;
               end
            end
            START: begin
               bit_idx <= '0;
               bit_cnt <= mid_hit ? '0 : bit_cnt + CNT_ONE;
            end
            DATA: begin
               if (bit_hit) begin
                  bit_cnt <= '0;
                  bit_idx <= bit_idx + 4'd1;
                  shreg   <= {rx_s, shreg[9:1]};
               end else begin
                  bit_cnt <= bit_cnt + CNT_ONE;
               end
            end
            DONE: begin
               bit_cnt   <= '0;
               rx_data   <= data_new;
               // A low stop bit may be a break; hold off until the line idles.
               wait_high <= ~stop_bit;
            end
            default: begin
               bit_cnt <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Status flags: frame completion takes priority over a host read
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxrdy <= 1'b0;
         perr  <= 1'b0;
         ferr  <= 1'b0;
         ovf   <= 1'b0;
      end else if (state == DONE) begin
         rxrdy <= 1'b1;
         perr  <= perr_new;
         ferr  <= ~stop_bit;
         ovf   <= rxrdy;
      end else if (rd_strobe) begin
         rxrdy <= 1'b0;
         perr  <= 1'b0;
         ferr  <= 1'b0;
         ovf   <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_engine
//  Purpose  : Self-checking bench for uart_rx_engine. Frames are driven on
//             rx; the expected byte, flags and completion cycle are queued
//             when each frame starts and compared when the cycle arrives.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_engine;

   localparam int DIV_W = 19;

   logic             clk;
   logic             rst;
   logic             rx;
   logic [DIV_W-1:0] baud_k;
   logic             eight;
   logic             pen;
   logic             ohel;
   logic             rd_strobe;
   logic [7:0]       rx_data;
   logic             rxrdy;
   logic             perr;
   logic             ferr;
   logic             ovf;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit m_rdy    = 1'b0;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       ov;
      logic       pre;
      int         due;
   } exp_t;

   exp_t sb[$];

   uart_rx_engine #(.DIV_W(DIV_W), .SYNC_N(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .baud_k    (baud_k),
      .eight     (eight),
      .pen       (pen),
      .ohel      (ohel),
      .rd_strobe (rd_strobe),
      .rx_data   (rx_data),
      .rxrdy     (rxrdy),
      .perr      (perr),
      .ferr      (ferr),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int frame_bits();
      return 7 + int'(eight) + int'(pen) + 1;
   endfunction

   // Cycle count at which rxrdy becomes visible for a frame whose start bit
   // is driven at the current negedge: 2 sync + 1 idle detect + half bit to
   // the start sample, one bit per sample, one DONE clock.
   function automatic int due_cycle();
      return cyc + 4 + int'(baud_k >> 1) + int'(baud_k) * frame_bits();
   endfunction

   task automatic push_exp(input logic [7:0] d, input logic par, input logic stop);
      exp_t e;
      logic [7:0] dd;
      dd    = eight ? d : {1'b0, d[6:0]};
      e.d   = dd;
      e.pe  = pen & ((^dd ^ par) != ohel);
      e.fe  = ~stop;
      e.ov  = m_rdy;
      e.pre = m_rdy;
      e.due = due_cycle();
      m_rdy = 1'b1;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge ending the stop bit.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit push);
      logic [9:0] fb;
      int nb;
      int k;
      nb = frame_bits();
      k  = int'(baud_k);
      fb = '0;
      for (int i = 0; i < 7 + int'(eight); i++) fb[i] = d[i];
      if (pen) fb[7 + int'(eight)] = par;
      fb[nb-1] = stop;
      if (push) push_exp(d, par, stop);
      rx = 1'b0;
      repeat (k) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         rx = fb[i];
         repeat (k) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic read_strobe();
      rd_strobe = 1'b1;
      @(negedge clk);
      rd_strobe = 1'b0;
      m_rdy     = 1'b0;
      @(negedge clk);
   endtask

   task automatic strobe_at(input int when);
      while (cyc != when) @(negedge clk);
      rd_strobe = 1'b1;
      @(negedge clk);
      rd_strobe = 1'b0;
   endtask

   task automatic chk_clear(input string tag);
      chk({tag, "_rxrdy"}, rxrdy, 0);
      chk({tag, "_perr"},  perr,  0);
      chk({tag, "_ferr"},  ferr,  0);
      chk({tag, "_ovf"},   ovf,   0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         if (cyc == sb[0].due - 1) begin
            chk("pre_rdy", rxrdy, sb[0].pre);
         end
         if (cyc == sb[0].due) begin
            chk("rx_data", rx_data, sb[0].d);
            chk("rxrdy",   rxrdy,   1);
            chk("perr",    perr,    sb[0].pe);
            chk("ferr",    ferr,    sb[0].fe);
            chk("ovf",     ovf,     sb[0].ov);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int due;
      rst       = 1'b1;
      rx        = 1'b1;
      baud_k    = DIV_W'(16);
      eight     = 1'b1;
      pen       = 1'b0;
      ohel      = 1'b0;
      rd_strobe = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data", rx_data, 8'h00);
      chk_clear("rst");

      // 8N1, A5
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      read_strobe();
      chk_clear("rd1");

      // 7E1, 0x41 with correct and wrong parity
      eight = 1'b0; pen = 1'b1; ohel = 1'b0;
      send_frame(8'h41, 1'b0, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      read_strobe();
      send_frame(8'hC1, 1'b1, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      read_strobe();
      chk_clear("rd2");

      // Minimum bit time, 8O1
      baud_k = DIV_W'(4); eight = 1'b1; pen = 1'b1; ohel = 1'b1;
      send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
      repeat (6) @(negedge clk);
      read_strobe();
      baud_k = DIV_W'(16); pen = 1'b0; ohel = 1'b0;

      // Short glitch is rejected as a false start
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk_clear("glitch");

      // Back-to-back frames without a read: overrun
      send_frame(8'h11, 1'b0, 1'b1, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      read_strobe();
      chk_clear("ovf_rd");

      // Framing error with a read in the DONE clock: set wins
      due = due_cycle();
      fork
         send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
         strobe_at(due - 1);
      join
      repeat (4) @(negedge clk);
      chk("setwin_rxrdy", rxrdy, 1);
      read_strobe();
      chk_clear("fe_rd");

      // Break: one frame of zeros with ferr, then no restart while low
      push_exp(8'h00, 1'b0, 1'b0);
      rx = 1'b0;
      repeat (16 * 14) @(negedge clk);
      read_strobe();
      repeat (64) @(negedge clk);
      chk("brk_hold", rxrdy, 0);
      rx = 1'b1;
      repeat (32) @(negedge clk);

      // Pending byte, then reset in the middle of a frame
      send_frame(8'h99, 1'b0, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      fork
         send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
         begin
            repeat (16 * 6) @(negedge clk);
            rst = 1'b1;
            #1;
            chk("mrst_data", rx_data, 8'h00);
            chk_clear("mrst");
            m_rdy = 1'b0;
            @(negedge clk);
            rst = 1'b0;
         end
      join
      repeat (8) @(negedge clk);
      chk_clear("post_rst");
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
      repeat (8) @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
